// File: rtl/bip_uart_sequencer.sv
// bip_uart_sequencer: pops a command byte from the RX FIFO, runs or
// single-steps the BIP core and pushes a result frame to the TX FIFO.
module bip_uart_sequencer #(
    parameter int unsigned      ACC_W      = 16,
    parameter int unsigned      CNT_W      = 16,
    parameter logic [7:0]       CMD_RUN    = 8'h01,
    parameter logic [7:0]       CMD_STEP   = 8'h02,
    parameter logic [CNT_W-1:0] MAX_CYCLES = 16'hFFF0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_empty,
    input  logic [7:0]       rx_data,
    output logic             rd_uart,
    input  logic             tx_full,
    output logic             wr_uart,
    output logic [7:0]       tx_data,
    input  logic             bip_halt,
    input  logic [ACC_W-1:0] bip_acc,
    output logic             bip_clr,
    output logic             bip_enable,
    output logic             busy
);

    localparam logic [7:0] ST_HALT = 8'h01;
    localparam logic [7:0] ST_TOUT = 8'h02;
    localparam logic [7:0] ST_STEP = 8'h03;
    localparam logic [7:0] ST_BAD  = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_CLEAR,
        S_RUN,
        S_STEP,
        S_STEP_CAP,
        S_SEND
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       cmd_q, cmd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]       status_q, status_d;
    logic [2:0]       byte_idx_q, byte_idx_d;

    logic [CNT_W-1:0] cnt_inc;
    logic [2:0]       last_idx;
    logic [7:0]       frame_byte;

    assign cnt_inc  = cnt_q + CNT_W'(1);
    // Rejected commands answer with the status byte alone.
    assign last_idx = (status_q == ST_BAD) ? 3'd0 : 3'd4;

    always_comb begin
        frame_byte = 8'h00;
        unique case (byte_idx_q)
            3'd0:    frame_byte = status_q;
            3'd1:    frame_byte = acc_q[7:0];
            3'd2:    frame_byte = acc_q[15:8];
            3'd3:    frame_byte = cnt_q[7:0];
            3'd4:    frame_byte = cnt_q[15:8];
            default: frame_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cmd_q      <= 8'h00;
            cnt_q      <= '0;
            acc_q      <= '0;
            status_q   <= 8'h00;
            byte_idx_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            status_q   <= status_d;
            byte_idx_q <= byte_idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        status_d   = status_q;
        byte_idx_d = byte_idx_q;
        rd_uart    = 1'b0;
        wr_uart    = 1'b0;
        tx_data    = 8'h00;
        bip_clr    = 1'b0;
        bip_enable = 1'b0;
        busy       = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (!rx_empty) begin
                    rd_uart    = 1'b1;
                    cmd_d      = rx_data;
                    byte_idx_d = 3'd0;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                if (cmd_q == CMD_RUN) begin
                    state_d = S_CLEAR;
                end else if (cmd_q == CMD_STEP) begin
                    state_d = S_STEP;
                end else begin
                    status_d = ST_BAD;
                    state_d  = S_SEND;
                end
            end
            S_CLEAR: begin
                bip_clr = 1'b1;
                cnt_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                // The cycle that observes halt was enabled, so it counts.
                bip_enable = 1'b1;
                cnt_d      = cnt_inc;
                if (bip_halt) begin
                    status_d = ST_HALT;
                    acc_d    = bip_acc;
                    state_d  = S_SEND;
                end else if (cnt_inc == MAX_CYCLES) begin
                    status_d = ST_TOUT;
                    acc_d    = bip_acc;
                    state_d  = S_SEND;
                end
            end
            S_STEP: begin
                bip_enable = 1'b1;
                cnt_d      = CNT_W'(1);
                state_d    = S_STEP_CAP;
            end
            S_STEP_CAP: begin
                acc_d    = bip_acc;
                status_d = ST_STEP;
                state_d  = S_SEND;
            end
            S_SEND: begin
                tx_data = frame_byte;
                if (!tx_full) begin
                    wr_uart = 1'b1;
                    if (byte_idx_q == last_idx) begin
                        byte_idx_d = 3'd0;
                        state_d    = S_IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bip_uart_sequencer.sv
// tb_bip_uart_sequencer: scoreboard bench with RX FIFO and BIP models;
// expected frames and strobe counts are queued at command issue.
module tb_bip_uart_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_empty = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rd_uart;
    logic        tx_full;
    logic        wr_uart;
    logic [7:0]  tx_data;
    logic        bip_halt;
    logic [15:0] bip_acc;
    logic        bip_clr;
    logic        bip_enable;
    logic        busy;

    always #5 clk = ~clk;

    bip_uart_sequencer #(
        .ACC_W      (16),
        .CNT_W      (16),
        .CMD_RUN    (8'h01),
        .CMD_STEP   (8'h02),
        .MAX_CYCLES (16'h0010)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_empty   (rx_empty),
        .rx_data    (rx_data),
        .rd_uart    (rd_uart),
        .tx_full    (tx_full),
        .wr_uart    (wr_uart),
        .tx_data    (tx_data),
        .bip_halt   (bip_halt),
        .bip_acc    (bip_acc),
        .bip_clr    (bip_clr),
        .bip_enable (bip_enable),
        .busy       (busy)
    );

    // RX FIFO model (show-ahead)
    logic [7:0] rx_q[$];
    logic       push_req;
    logic [7:0] push_byte;

    initial forever begin
        @(posedge clk);
        if (rd_uart && rx_q.size() > 0) void'(rx_q.pop_front());
        if (push_req) rx_q.push_back(push_byte);
        rx_empty <= (rx_q.size() == 0);
        rx_data  <= (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    end

    // BIP model: acc takes tbl[pc] on each executed cycle
    logic [7:0]  pc = 8'h00;
    logic [15:0] acc_m = 16'h0000;
    logic [15:0] tbl [16];
    logic        halt_en;
    logic [7:0]  halt_pc;
    logic        model_clr;

    always @(posedge clk) begin
        if (bip_clr || model_clr) begin
            pc    <= 8'h00;
            acc_m <= 16'h0000;
        end else if (bip_enable && !bip_halt) begin
            pc    <= pc + 8'h01;
            acc_m <= tbl[pc[3:0]];
        end
    end

    assign bip_halt = halt_en && (pc == halt_pc);
    assign bip_acc  = acc_m;

    // Scoreboard
    typedef struct {
        int rd;
        int clr;
        int en;
        int bend;
    } cmd_exp_t;

    logic [7:0] exp_b[$];
    cmd_exp_t   exp_c[$];

    int checks = 0;
    int fails = 0;
    int done_cmds = 0;
    int tmo_cnt = 0;
    int tmo_seen = 0;
    bit final_req = 1'b0;
    bit final_done = 1'b0;

    // Monitor
    initial begin
        int  bi = 0;
        int  ci = 0;
        int  n_rd = 0;
        int  n_clr = 0;
        int  n_en = 0;
        bit  prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                checks++;
                if ({rd_uart, wr_uart, bip_clr, bip_enable,
                     busy, tx_data} != 13'h0) begin
                    fails++;
                    $display("FAIL reset_state got %b want 0",
                             {rd_uart, wr_uart, bip_clr,
                              bip_enable, busy, tx_data});
                end
                n_rd = 0;
                n_clr = 0;
                n_en = 0;
                prev_busy = 1'b0;
            end else begin
                if (prev_busy && !busy) begin
                    checks++;
                    if (ci >= exp_c.size()) begin
                        fails++;
                        $display("FAIL unexpected_done got %0d want %0d",
                                 ci + 1, exp_c.size());
                    end else if (n_rd != exp_c[ci].rd ||
                                 n_clr != exp_c[ci].clr ||
                                 n_en != exp_c[ci].en ||
                                 bi != exp_c[ci].bend) begin
                        fails++;
                        $display("FAIL cmd%0d rd/clr/en/bytes got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                                 ci, n_rd, n_clr, n_en, bi,
                                 exp_c[ci].rd, exp_c[ci].clr,
                                 exp_c[ci].en, exp_c[ci].bend);
                    end
                    ci++;
                    done_cmds++;
                    n_rd = 0;
                    n_clr = 0;
                    n_en = 0;
                end
                if (rd_uart) begin
                    checks++;
                    if (busy) begin
                        fails++;
                        $display("FAIL pop_while_busy got 1 want 0");
                    end
                    n_rd++;
                end
                if (bip_clr) n_clr++;
                if (bip_enable) n_en++;
                if (tx_full) begin
                    checks++;
                    if (wr_uart) begin
                        fails++;
                        $display("FAIL wr_while_full got 1 want 0");
                    end
                end
                if (wr_uart) begin
                    checks++;
                    if (bi >= exp_b.size()) begin
                        fails++;
                        $display("FAIL extra_byte got %02h want none",
                                 tx_data);
                    end else if (tx_data != exp_b[bi]) begin
                        fails++;
                        $display("FAIL byte[%0d] got %02h want %02h",
                                 bi, tx_data, exp_b[bi]);
                    end
                    bi++;
                end
                prev_busy = busy;
            end
            if (tmo_cnt != tmo_seen) begin
                checks++;
                fails++;
                tmo_seen++;
            end
            if (final_req && !final_done) begin
                checks++;
                if (bi != exp_b.size() || ci != exp_c.size()) begin
                    fails++;
                    $display("FAIL drain got %0d/%0d want %0d/%0d",
                             bi, ci, exp_b.size(), exp_c.size());
                end
                final_done = 1'b1;
            end
        end
    end

    // Stimulus
    task automatic push_cmd(input logic [7:0] b);
        @(negedge clk);
        push_byte = b;
        push_req  = 1'b1;
        @(negedge clk);
        push_req  = 1'b0;
    endtask

    task automatic exp_frame(input logic [7:0] st,
                             input logic [15:0] acc,
                             input logic [15:0] cnt,
                             input int clr,
                             input int en);
        cmd_exp_t r;
        exp_b.push_back(st);
        exp_b.push_back(acc[7:0]);
        exp_b.push_back(acc[15:8]);
        exp_b.push_back(cnt[7:0]);
        exp_b.push_back(cnt[15:8]);
        r.rd   = 1;
        r.clr  = clr;
        r.en   = en;
        r.bend = exp_b.size();
        exp_c.push_back(r);
    endtask

    task automatic exp_bad();
        cmd_exp_t r;
        exp_b.push_back(8'hFF);
        r.rd   = 1;
        r.clr  = 0;
        r.en   = 0;
        r.bend = exp_b.size();
        exp_c.push_back(r);
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cmds < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done_cmds < target) begin
            $display("FAIL timeout cmd%0d got %0d want %0d",
                     target, done_cmds, target);
            tmo_cnt++;
        end
    endtask

    task automatic wait_sig(input bit use_wr, input int budget);
        int n = 0;
        while (!(use_wr ? wr_uart : bip_enable) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!(use_wr ? wr_uart : bip_enable)) begin
            $display("FAIL timeout %s got 0 want 1",
                     use_wr ? "wr_uart" : "bip_enable");
            tmo_cnt++;
        end
    endtask

    task automatic seq_prog();
        for (int i = 0; i < 16; i++) tbl[i] = 16'(i + 1);
    endtask

    initial begin
        int n;
        reset     = 1'b0;
        tx_full   = 1'b0;
        push_req  = 1'b0;
        push_byte = 8'h00;
        model_clr = 1'b0;
        halt_en   = 1'b0;
        halt_pc   = 8'h00;
        seq_prog();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // RUN, halts on 6th cycle with ACC=5
        halt_en = 1'b1;
        halt_pc = 8'd5;
        exp_frame(8'h01, 16'h0005, 16'h0006, 1, 6);
        push_cmd(8'h01);
        wait_done(1, 200);

        // Two STEPs queued back to back, program LDI 3; ADDI 4
        halt_en = 1'b0;
        tbl[0] = 16'h0003;
        tbl[1] = 16'h0007;
        @(negedge clk);
        model_clr = 1'b1;
        @(negedge clk);
        model_clr = 1'b0;
        exp_frame(8'h03, 16'h0003, 16'h0001, 0, 1);
        exp_frame(8'h03, 16'h0007, 16'h0001, 0, 1);
        push_cmd(8'h02);
        push_cmd(8'h02);
        wait_done(3, 200);

        // Unknown command
        exp_bad();
        push_cmd(8'h7A);
        wait_done(4, 200);

        // Never-halting RUN hits the timeout
        seq_prog();
        exp_frame(8'h02, 16'h000F, 16'h0010, 1, 16);
        push_cmd(8'h01);
        wait_done(5, 200);

        // TX FIFO full for 20 cycles after the first frame byte
        halt_en = 1'b1;
        halt_pc = 8'd5;
        exp_frame(8'h01, 16'h0005, 16'h0006, 1, 6);
        push_cmd(8'h01);
        wait_sig(1'b1, 200);
        @(posedge clk);
        #1 tx_full = 1'b1;
        repeat (20) @(posedge clk);
        #1 tx_full = 1'b0;
        wait_done(6, 200);

        // Reset in the middle of a RUN, then a clean RUN
        halt_en = 1'b0;
        push_cmd(8'h01);
        wait_sig(1'b0, 200);
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        halt_en = 1'b1;
        halt_pc = 8'd5;
        exp_frame(8'h01, 16'h0005, 16'h0006, 1, 6);
        push_cmd(8'h01);
        wait_done(7, 200);

        repeat (3) @(negedge clk);
        final_req = 1'b1;
        n = 0;
        while (!final_done && n < 10) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule

// File: doc/bip_uart_sequencer.md
Name: bip_uart_sequencer

Overview:
- Command sequencer between the UART RX/TX FIFOs and the BIP processor core inside the top-level design.
- Pops one command byte from the RX FIFO and decodes it.
- Runs the BIP to halt, or single-steps it, while counting enabled cycles.
- Pushes a fixed-format response frame (status, accumulator, cycle count) into the TX FIFO, then returns to idle.

Parameters:
- ACC_W, 16, BIP accumulator width (must be 16; frame carries 2 ACC bytes)
- CNT_W, 16, cycle counter width (must be 16)
- CMD_RUN, 8'h01, command byte: clear BIP, run until halt
- CMD_STEP, 8'h02, command byte: execute exactly one BIP cycle, no clear
- MAX_CYCLES, 16'hFFF0, RUN timeout in enabled cycles

Ports:
- clk  in  1  system clock (100 MHz)
- reset  in  1  asynchronous, active-low reset
- rx_empty  in  1  RX FIFO empty flag
- rx_data  in  8  RX FIFO head byte (show-ahead, valid while rx_empty=0)
- rd_uart  out  1  RX FIFO pop strobe, one cycle
- tx_full  in  1  TX FIFO full flag
- wr_uart  out  1  TX FIFO push strobe, one cycle
- tx_data  out  8  byte pushed with wr_uart
- bip_halt  in  1  BIP halt flag (level)
- bip_acc  in  ACC_W  BIP accumulator value
- bip_clr  out  1  one-cycle synchronous clear of BIP PC/ACC
- bip_enable  out  1  BIP clock-enable
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; rd_uart, wr_uart, bip_clr, bip_enable, busy = 0; tx_data=8'h00; cmd, cnt, acc_q, status, byte_idx = 0.
- IDLE: when rx_empty=0, rd_uart=1 for that cycle and cmd<=rx_data; next state DECODE. While rx_empty=1, remain in IDLE with no strobes.
- DECODE (1 cycle):
  - cmd==CMD_RUN -> CLEAR.
  - cmd==CMD_STEP -> STEP.
  - Any other value -> status<=8'hFF, frame length=1 -> SEND.
- CLEAR (1 cycle): bip_clr=1; cnt<=0 -> RUN.
- RUN: bip_enable=1 every cycle in state; cnt increments each enabled cycle.
  - bip_halt sampled 1 -> bip_enable drops next cycle; status<=8'h01; acc_q<=bip_acc; go SEND.
  - Halt check has priority over timeout. If cnt reaches MAX_CYCLES with bip_halt=0 -> status<=8'h02, capture acc, go SEND.
  - A halt present on the first RUN cycle still counts that cycle (cnt=1).
- STEP (1 cycle): bip_enable=1 exactly one cycle; cnt<=1. Next cycle (STEP_CAP) acc_q<=bip_acc; status<=8'h03 -> SEND. No bip_clr. STEP on a halted BIP still reports status 8'h03; the BIP itself ignores the enable.
- SEND:
  - Frame for status 01/02/03 is 5 bytes, in order: status, acc_q[7:0], acc_q[15:8], cnt[7:0], cnt[15:8].
  - Frame for status FF is 1 byte.
  - Each byte: when tx_full=0, wr_uart=1 with tx_data=byte for one cycle, then byte_idx increments. When tx_full=1, hold with wr_uart=0, no data loss, no duplication.
  - After the last byte -> IDLE. Minimum SEND duration = frame length cycles.
- RX bytes arriving while busy stay in the RX FIFO; exactly one pop per command; never pop in any state but IDLE.
- cnt is captured at the end of the command and never wraps during RUN; the timeout fires first.
- Reset asserted mid-RUN or mid-SEND: immediate return to IDLE, bip_enable=0, partial frame abandoned; the next command starts clean.
- Latency, command pop to first wr_uart with tx_full=0:
  - RUN = 3 + cnt cycles.
  - STEP = 4 cycles.
  - Unknown = 2 cycles.

Test Plan:
- UART byte 8'h01 at 19200 baud (52083 ns/bit), BIP program halts after 6 cycles with ACC=16'h0005 -> one rd_uart pulse, one bip_clr pulse, bip_enable high 6 cycles, TX bytes 01,05,00,06,00.
- Command 8'h02 twice on a cleared BIP with program "LDI 3" -> first frame 03,03,00,01,00; bip_clr never asserted.
- Command 8'h7A -> single TX byte FF, bip_enable never asserted, back to IDLE with busy=0.
- RUN on a program that never halts, MAX_CYCLES=16'h0010 -> bip_enable high exactly 16 cycles, frame starts 02 and ends 10,00.
- tx_full forced high for 20 cycles after the first frame byte -> wr_uart stays 0 while full, remaining 4 bytes sent in order once tx_full=0, none duplicated.
- reset pulled low for 3 cycles during RUN, then command 8'h01 sent -> outputs at reset values immediately; the second command produces a complete, correct 5-byte frame.
